// File: rtl/display_pkg.sv
// display_pkg: state encoding and frame constants shared by the display UART blocks.
package display_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
    localparam logic [7:0] HEADER = 8'h0C;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; load is accepted in IDLE or on the final
// stop-bit cycle (done_o) so consecutive bytes go out without an idle gap.
module uart_tx_byte
    import display_pkg::*;
#(
    parameter int ClksPerBit = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       done_o
);
    localparam int CW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            baud_end;
    assign baud_end = baud_q == CW'(ClksPerBit - 1);
    assign done_o   = (state_q == STOP) && baud_end;
    assign txd_o    = tx_q;
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = START;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            default: begin
                if (baud_end) begin
                    state_d = load_i ? START : IDLE;
                    shift_d = load_i ? data_i : shift_q;
                    tx_d    = !load_i;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: rtl/display_uart_tx.sv
// display_uart_tx: sends a header byte followed by a snapshot of DisplayBuffer
// over UART, on Refresh or on an AutoRefresh-detected change.
module display_uart_tx
    import display_pkg::*;
#(
    parameter int DisplayBufferSize = 256,
    parameter int ClksPerBit        = 434
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DisplayBufferSize-1:0] DisplayBuffer,
    input  logic                         Refresh,
    input  logic                         AutoRefresh,
    output logic                         TxD,
    output logic                         Busy,
    output logic                         FrameDone
);
    localparam int NCHR = DisplayBufferSize / 8;
    localparam int IW   = $clog2(NCHR + 1);
    logic [DisplayBufferSize-1:0] snap_q, snap_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic                         busy_q, busy_d;
    logic                         pend_q, pend_d;
    logic                         fd_q, fd_d;
    logic                         trigger, last, load, byte_done;
    logic [7:0]                   load_byte;
    assign trigger   = !busy_q && (Refresh || pend_q || (AutoRefresh && DisplayBuffer != snap_q));
    assign last      = idx_q == IW'(NCHR);
    assign load      = trigger || (byte_done && !last);
    // character idx_q is the next byte once the previous stop bit finishes
    assign load_byte = trigger ? HEADER : snap_q[(DisplayBufferSize - 1) - 8 * int'(idx_q) -: 8];
    always_comb begin
        snap_d = snap_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        pend_d = pend_q;
        fd_d   = 1'b0;
        if (trigger) begin
            snap_d = DisplayBuffer;
            idx_d  = '0;
            busy_d = 1'b1;
            pend_d = 1'b0;
        end else if (busy_q) begin
            pend_d = pend_q || Refresh;
            if (byte_done) begin
                idx_d  = last ? '0 : idx_q + 1'b1;
                busy_d = !last;
                fd_d   = last;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            pend_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            fd_q   <= fd_d;
        end
    end
    uart_tx_byte #(.ClksPerBit(ClksPerBit)) u_ser (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (load),
        .data_i (load_byte),
        .txd_o  (TxD),
        .done_o (byte_done)
    );
    assign Busy      = busy_q;
    assign FrameDone = fd_q;
endmodule

// File: doc/display_uart_tx.md
DISPLAY_UART_TX -- requirements
Module: display_uart_tx

Interface
REQ-001 SHALL have parameter DisplayBufferSize, default 256: width of DisplayBuffer in bits, a multiple of 8, 8 to 256.
REQ-002 SHALL have parameter ClksPerBit, default 434: clk cycles per UART bit, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port DisplayBuffer  input  DisplayBufferSize  display memory contents; character 0 occupies bits [DisplayBufferSize-1 : DisplayBufferSize-8].
REQ-006 SHALL have port Refresh  input  1  request to transmit one frame, sampled each cycle.
REQ-007 SHALL have port AutoRefresh  input  1  when high, a frame is also requested whenever DisplayBuffer differs from the last transmitted snapshot.
REQ-008 SHALL have port TxD  output  1  UART serial line, 8N1, idle high.
REQ-009 SHALL have port Busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port FrameDone  output  1  one-cycle pulse at the end of each frame.

Function
REQ-011 SHALL use the frame format: header byte 8'h0C, then NCHR = DisplayBufferSize/8 character bytes, character 0 first.
REQ-012 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with every bit held for exactly ClksPerBit cycles.
REQ-013 SHALL send bytes back-to-back, with no idle gap between a stop bit and the next start bit.
REQ-014 SHALL raise a trigger when Refresh is high, or when AutoRefresh is high and DisplayBuffer != snapshot, in IDLE.
REQ-015 SHALL, when a trigger is sampled in IDLE at edge k, latch DisplayBuffer into the snapshot at edge k.
REQ-016 SHALL, for the same trigger, drive Busy=1 and TxD=0 (header start bit) from edge k.
REQ-017 SHALL transmit only from the snapshot; DisplayBuffer changes during a frame do not affect that frame.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP with these transitions:
- IDLE->START on trigger.
- START->DATA after ClksPerBit cycles.
- DATA->STOP after 8 bits.
- STOP->START if bytes remain, else STOP->IDLE.
REQ-019 SHALL keep a byte index 0..NCHR (0 = header) that advances on each STOP exit.
REQ-020 SHALL keep a bit index 0..7 and a baud counter 0..ClksPerBit-1; both wrap to 0 at terminal count.
REQ-021 SHALL, on the edge where the last stop bit completes, pulse FrameDone for one cycle, drive Busy=0 and enter IDLE.
REQ-022 SHALL set a single pending flag when Refresh is high while Busy; multiple requests collapse into one.
REQ-023 SHALL, with pending set at frame end, start the next frame at the following edge, latch a fresh snapshot and clear pending.
REQ-024 SHALL not set the pending flag from an AutoRefresh mismatch during a frame; the mismatch is re-evaluated in IDLE.
REQ-025 SHALL give Refresh and an AutoRefresh mismatch in the same cycle the effect of a single trigger.

Reset
REQ-026 SHALL, while reset_n=0, hold TxD=1, Busy=0, FrameDone=0, state IDLE, all counters 0, pending 0, snapshot all zeros, regardless of clk.
REQ-027 SHALL, on reset assertion mid-frame, abort the frame immediately with TxD=1 and no FrameDone pulse.
REQ-028 SHALL, after reset release, accept a trigger from the first posedge clk.

Structure
REQ-029 SHALL place the FSM state encoding (2-bit) and the header constant 8'h0C in a shared package (display_pkg).
REQ-030 SHALL contain one sub-module, uart_tx_byte: byte serializer with load/done handshake, parameterised by ClksPerBit.
REQ-031 SHALL keep frame sequencing, snapshot and pending logic in display_uart_tx.

Verification
REQ-032 SHALL verify basic frame: ClksPerBit=4, DisplayBufferSize=16, DisplayBuffer=16'h4142, Refresh for 1 cycle -> bytes 0x0C, 0x41, 0x42 decoded; Busy high 120 cycles; one FrameDone.
REQ-033 SHALL verify bit timing: on the header start bit, TxD low for exactly 4 cycles, then data 0,0,1,1,0,0,0,0, then stop high for 4 cycles.
REQ-034 SHALL verify snapshot isolation: DisplayBuffer changed to 16'h5A5A at cycle 50 of a frame -> frame still sends 0x41, 0x42.
REQ-035 SHALL verify pending and AutoRefresh:
- 3 Refresh pulses during a frame -> exactly one more frame, starting the cycle after FrameDone.
- AutoRefresh=1 with unchanged buffer -> no further frames.
REQ-036 SHALL verify reset mid-frame: reset_n low at cycle 30 -> TxD=1 and Busy=0 asynchronously; no FrameDone; Refresh after release -> full frame from header.
